// File: rtl/core_ctrl_if.sv
// core_ctrl_if: host/core-facing bus of the core_ctrl instruction sequencer.
// The master side (host or testbench) issues tile commands, streams words in and
// reports ofifo status. The slave side (core_ctrl) returns the inst word, the
// xmem write data and the tile status.
interface core_ctrl_if #(
    parameter int row = 8,
    parameter int bw  = 4
) ();
    logic                start;
    logic [10:0]         cfg_len;
    logic [10:0]         cfg_kbase;
    logic                cfg_mode;
    logic                in_valid;
    logic                in_ready;
    logic [bw*row-1:0]   in_data;
    logic                core_valid;
    logic [34:0]         inst;
    logic [bw*row-1:0]   D_xmem;
    logic                busy;
    logic                done;

    modport master (
        output start, cfg_len, cfg_kbase, cfg_mode, in_valid, in_data, core_valid,
        input  in_ready, inst, D_xmem, busy, done
    );

    modport slave (
        input  start, cfg_len, cfg_kbase, cfg_mode, in_valid, in_data, core_valid,
        output in_ready, inst, D_xmem, busy, done
    );
endinterface

// File: rtl/core_ctrl.sv
// core_ctrl: tile sequencer for core. Streams activations and kernel words into
// xmem, loads the kernel into the PEs, runs the activations through the array,
// then drains the ofifo into psum memory. Every output is registered.
// Optional feature: define CORE_CTRL_OS_MODE_EN to drive inst[34] from the
// cfg_mode sampled at start; without it inst[34] is always 0 (WS only).
module core_ctrl #(
    parameter int row = 8,
    parameter int bw  = 4,
    parameter int num = 2048,
    parameter int col = 8
) (
    input logic        clk,
    input logic        reset,
    core_ctrl_if.slave bus
);
    localparam int AW = $clog2(num);
    localparam int DW = bw * row;

    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [AW-1:0] COL_W     = AW'(col);
    localparam logic [AW-1:0] COL_LAST  = AW'(col - 1);
    localparam logic [AW-1:0] LOAD_LAST = AW'(2 * col);
    localparam logic [AW-1:0] LD_GAP    = AW'(2 * col + 1);
    localparam logic [AW-1:0] FLUSH_W   = AW'(row + col);

    // SRAM enables are active low, so the idle word keeps both CEN/WEN pairs high.
    localparam logic [34:0] NOP = (35'd1 << 32) | (35'd1 << 31) | (35'd1 << 19) | (35'd1 << 18);

    typedef enum logic [2:0] {
        IDLE,
        WR_X,
        WR_W,
        LD_W,
        EXEC,
        DRAIN,
        DONE
    } ctrlState_e;

    ctrlState_e    stateReg, stateNext;
    logic [AW-1:0] cntReg, cntNext;        // phase-local step / word counter
    logic [AW-1:0] pcntReg, pcntNext;      // psum writes issued
    logic [AW-1:0] ocntReg, ocntNext;      // ofifo reads issued
    logic [AW-1:0] lenReg, lenNext;
    logic [AW-1:0] kbaseReg, kbaseNext;
    logic          modeReg, modeNext;
    logic          rdIssuedReg, rdIssuedNext;  // previous step issued an xmem read
    logic          psumPendReg, psumPendNext;  // previous step popped the ofifo
    logic [34:0]   instReg, instNext;
    logic [DW-1:0] dXmemReg, dXmemNext;
    logic          inReadyReg, inReadyNext;
    logic          busyReg, busyNext;
    logic          doneReg, doneNext;

    logic          modeOut;
    logic          modeBit;
    logic          psumCen, psumWen, xmemCen, xmemWen;
    logic [AW-1:0] psumA, xmemA;
    logic          ofifoRd, l0Rd, l0Wr, execute, load;

`ifdef CORE_CTRL_OS_MODE_EN
    assign modeOut = modeReg;
`else
    logic unusedMode;
    assign modeOut    = 1'b0;
    assign unusedMode = modeReg;
`endif

    // Next-state, counters and the next instruction word for the current step.
    always_comb begin
        stateNext    = stateReg;
        cntNext      = cntReg;
        pcntNext     = pcntReg;
        ocntNext     = ocntReg;
        lenNext      = lenReg;
        kbaseNext    = kbaseReg;
        modeNext     = modeReg;
        rdIssuedNext = 1'b0;
        psumPendNext = 1'b0;
        inReadyNext  = inReadyReg;
        busyNext     = busyReg;
        doneNext     = 1'b0;
        dXmemNext    = dXmemReg;
        modeBit      = modeOut;
        psumCen      = 1'b1;
        psumWen      = 1'b1;
        psumA        = '0;
        xmemCen      = 1'b1;
        xmemWen      = 1'b1;
        xmemA        = '0;
        ofifoRd      = 1'b0;
        l0Rd         = 1'b0;
        // SRAM Q arrives one cycle after the read, so L0 is written one step later.
        l0Wr         = rdIssuedReg;
        execute      = 1'b0;
        load         = 1'b0;

        case (stateReg)
            IDLE: begin
                modeBit     = 1'b0;
                inReadyNext = 1'b0;
                busyNext    = 1'b0;
                if (bus.start) begin
                    lenNext     = (bus.cfg_len == '0) ? ONE : bus.cfg_len;
                    kbaseNext   = bus.cfg_kbase;
                    modeNext    = bus.cfg_mode;
                    cntNext     = '0;
                    pcntNext    = '0;
                    ocntNext    = '0;
                    inReadyNext = 1'b1;
                    busyNext    = 1'b1;
                    stateNext   = WR_X;
                end
            end

            WR_X: begin
                if (bus.in_valid && inReadyReg) begin
                    xmemCen   = 1'b0;
                    xmemWen   = 1'b0;
                    xmemA     = cntReg;
                    dXmemNext = bus.in_data;
                    if (cntReg == lenReg - ONE) begin
                        cntNext   = '0;
                        stateNext = WR_W;
                    end else begin
                        cntNext = cntReg + ONE;
                    end
                end
            end

            WR_W: begin
                if (bus.in_valid && inReadyReg) begin
                    xmemCen   = 1'b0;
                    xmemWen   = 1'b0;
                    xmemA     = kbaseReg + cntReg;
                    dXmemNext = bus.in_data;
                    if (cntReg == COL_LAST) begin
                        cntNext     = '0;
                        inReadyNext = 1'b0;
                        stateNext   = LD_W;
                    end else begin
                        cntNext = cntReg + ONE;
                    end
                end
            end

            LD_W: begin
                // Steps 0..col-1 read kernel words, step col is the trailing L0
                // write, then col load steps, then one idle step before EXEC.
                cntNext = cntReg + ONE;
                if (cntReg < COL_W) begin
                    xmemCen      = 1'b0;
                    xmemA        = kbaseReg + cntReg;
                    rdIssuedNext = 1'b1;
                end else if ((cntReg > COL_W) && (cntReg <= LOAD_LAST)) begin
                    l0Rd = 1'b1;
                    load = 1'b1;
                end else if (cntReg == LD_GAP) begin
                    cntNext   = '0;
                    stateNext = EXEC;
                end
            end

            EXEC: begin
                // Activation reads first, then row+col flush steps so the last
                // activation propagates through the whole array.
                execute = 1'b1;
                cntNext = cntReg + ONE;
                if (cntReg < lenReg) begin
                    xmemCen      = 1'b0;
                    xmemA        = cntReg;
                    l0Rd         = 1'b1;
                    rdIssuedNext = 1'b1;
                end
                if (cntReg == lenReg + FLUSH_W - ONE) begin
                    cntNext   = '0;
                    stateNext = DRAIN;
                end
            end

            DRAIN: begin
                // ofifo data is valid the cycle after the pop, so the psum write
                // trails each ofifo_rd by one step. Pops stop once len rows are out.
                if (psumPendReg) begin
                    psumCen  = 1'b0;
                    psumWen  = 1'b0;
                    psumA    = pcntReg;
                    pcntNext = pcntReg + ONE;
                    if (pcntReg == lenReg - ONE) begin
                        stateNext = DONE;
                    end
                end
                if (bus.core_valid && (ocntReg < lenReg)) begin
                    ofifoRd      = 1'b1;
                    ocntNext     = ocntReg + ONE;
                    psumPendNext = 1'b1;
                end
            end

            DONE: begin
                doneNext  = 1'b1;
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase

        instNext = {modeBit, 1'b0, psumCen, psumWen, psumA, xmemCen, xmemWen, xmemA,
                    ofifoRd, 1'b0, 1'b0, l0Rd, l0Wr, execute, load};
    end

    // State and output registers; reset aborts any tile straight back to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg    <= IDLE;
            cntReg      <= '0;
            pcntReg     <= '0;
            ocntReg     <= '0;
            lenReg      <= '0;
            kbaseReg    <= '0;
            modeReg     <= 1'b0;
            rdIssuedReg <= 1'b0;
            psumPendReg <= 1'b0;
            instReg     <= NOP;
            dXmemReg    <= '0;
            inReadyReg  <= 1'b0;
            busyReg     <= 1'b0;
            doneReg     <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            cntReg      <= cntNext;
            pcntReg     <= pcntNext;
            ocntReg     <= ocntNext;
            lenReg      <= lenNext;
            kbaseReg    <= kbaseNext;
            modeReg     <= modeNext;
            rdIssuedReg <= rdIssuedNext;
            psumPendReg <= psumPendNext;
            instReg     <= instNext;
            dXmemReg    <= dXmemNext;
            inReadyReg  <= inReadyNext;
            busyReg     <= busyNext;
            doneReg     <= doneNext;
        end
    end

    assign bus.inst     = instReg;
    assign bus.D_xmem   = dXmemReg;
    assign bus.in_ready = inReadyReg;
    assign bus.busy     = busyReg;
    assign bus.done     = doneReg;
endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed-plus-random bench for core_ctrl. Each tile is driven
// cycle by cycle, the DUT outputs are logged, and the log is compared against
// the event sequence the tile rules imply (write list, read list, L0/load/exec
// timing, drain ordering, done/busy timing, mode bit).
module tb_core_ctrl;
    localparam int ROW  = 8;
    localparam int BW   = 4;
    localparam int COL  = 8;
    localparam int DW   = BW * ROW;
    localparam int MAXC = 4096;
    localparam logic [34:0] NOP = (35'd1 << 32) | (35'd1 << 31) | (35'd1 << 19) | (35'd1 << 18);

    logic clk   = 1'b0;
    logic reset = 1'b0;

    core_ctrl_if #(.row(ROW), .bw(BW)) bus ();

    core_ctrl #(.row(ROW), .bw(BW), .num(2048), .col(COL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;

    logic [34:0]   instLog  [0:MAXC-1];
    logic [DW-1:0] dLog     [0:MAXC-1];
    bit            busyLog  [0:MAXC-1];
    bit            doneLog  [0:MAXC-1];
    bit            readyLog [0:MAXC-1];
    bit            cvLog    [0:MAXC-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one tile and check it. vMode: 0 back-to-back, 1 toggling, 2 random.
    task automatic runTile(input int len, input logic [10:0] kbase, input logic mode,
                           input int vMode, input int cvPct, input bit spurious,
                           input bit abortInExec);
        int            effLen;
        int            total;
        int            wi;
        int            c;
        int            lastC;
        int            doneAt;
        logic [DW-1:0] words[$];
        int            wrA[$];
        logic [DW-1:0] wrD[$];
        int            rdA[$];
        int            rdC[$];
        int            loadC[$];
        int            exeC[$];
        int            ofC[$];
        int            psA[$];
        int            psC[$];
        int            wrBad, rdBad, l0Bad, ofBad, psBad, modeBad, badBits, doneCnt, exBad, got;
        logic          expMode;
        bit            expOf;

        effLen = (len == 0) ? 1 : len;
        total  = effLen + COL;
        for (int i = 0; i < total; i++) words.push_back(DW'($urandom));
`ifdef CORE_CTRL_OS_MODE_EN
        expMode = mode;
`else
        expMode = 1'b0;
`endif
        @(negedge clk);
        instLog[0]  = bus.inst;
        dLog[0]     = bus.D_xmem;
        busyLog[0]  = bus.busy;
        doneLog[0]  = bus.done;
        readyLog[0] = bus.in_ready;
        bus.start      = 1'b1;
        bus.cfg_len    = len[10:0];
        bus.cfg_kbase  = kbase;
        bus.cfg_mode   = mode;
        bus.in_valid   = 1'b0;
        bus.core_valid = 1'b0;
        cvLog[0]       = 1'b0;
        wi     = 0;
        doneAt = -1;
        lastC  = 0;
        for (c = 1; c < MAXC; c++) begin
            @(negedge clk);
            instLog[c]  = bus.inst;
            dLog[c]     = bus.D_xmem;
            busyLog[c]  = bus.busy;
            doneLog[c]  = bus.done;
            readyLog[c] = bus.in_ready;
            lastC       = c;
            if (bus.done && doneAt < 0) doneAt = c;
            if (abortInExec && bus.inst[1]) begin
                reset     = 1'b0;
                bus.start = 1'b0;
                bus.in_valid = 1'b0;
                @(negedge clk);
                check("abort_inst_nop", 64'(bus.inst), 64'(NOP));
                check("abort_busy", 64'(bus.busy), 64'd0);
                check("abort_in_ready", 64'(bus.in_ready), 64'd0);
                check("abort_done", 64'(bus.done), 64'd0);
                reset = 1'b1;
                @(negedge clk);
                check("abort_stays_idle", 64'(bus.busy), 64'd0);
                $display("tile abort len=%0d kbase=%03h reset mid-EXEC at cycle %0d", len, kbase, c);
                return;
            end
            if (doneAt >= 0 && c >= doneAt + 2) break;
            if (bus.in_valid && readyLog[c-1]) wi++;
            if (spurious && doneAt < 0 && (c % 9) == 4) begin
                bus.start     = 1'b1;
                bus.cfg_len   = 11'($urandom_range(1, 30));
                bus.cfg_kbase = 11'($urandom);
                bus.cfg_mode  = ~mode;
            end else begin
                bus.start = 1'b0;
            end
            if (wi < total) begin
                case (vMode)
                    0:       bus.in_valid = 1'b1;
                    1:       bus.in_valid = c[0];
                    default: bus.in_valid = ($urandom_range(0, 99) < 60);
                endcase
                bus.in_data = words[wi];
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.core_valid = ($urandom_range(0, 99) < cvPct);
            cvLog[c]       = bus.core_valid;
        end
        bus.start      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.core_valid = 1'b0;

        check("tile_completes", 64'(doneAt >= 0), 64'd1);
        if (doneAt < 0) return;

        wrBad = 0; rdBad = 0; l0Bad = 0; ofBad = 0; psBad = 0;
        modeBad = 0; badBits = 0; doneCnt = 0; exBad = 0; got = 0;
        for (int t = 0; t <= lastC; t++) begin
            logic [34:0] w;
            w = instLog[t];
            if (!w[19] && !w[18]) begin wrA.push_back(int'(w[17:7])); wrD.push_back(dLog[t]); end
            if (!w[19] &&  w[18]) begin rdA.push_back(int'(w[17:7])); rdC.push_back(t); end
            if (w[0]) loadC.push_back(t);
            if (w[1]) exeC.push_back(t);
            if (w[6]) ofC.push_back(t);
            if (!w[32] && !w[31]) begin psA.push_back(int'(w[30:20])); psC.push_back(t); end
            if (doneLog[t]) doneCnt++;
            if (w[33] || w[5] || w[4]) badBits++;
            if (t >= 2 && t <= doneAt && w[34] !== expMode) modeBad++;
            if (t >= 1 && w[2] !== (!instLog[t-1][19] && instLog[t-1][18])) l0Bad++;
        end

        check("start_busy", 64'(busyLog[1]), 64'd1);
        check("start_in_ready", 64'(readyLog[1]), 64'd1);
        check("xmem_write_count", 64'(wrA.size()), 64'(total));
        if (wrA.size() == total) begin
            for (int i = 0; i < total; i++) begin
                int ea;
                ea = (i < effLen) ? i : ((int'(kbase) + i - effLen) % 2048);
                if (wrA[i] != ea || wrD[i] !== words[i]) wrBad++;
            end
            check("xmem_write_seq", 64'(wrBad), 64'd0);
        end
        check("xmem_read_count", 64'(rdA.size()), 64'(total));
        if (rdA.size() == total) begin
            for (int k = 0; k < COL; k++) if (rdA[k] != (int'(kbase) + k) % 2048) rdBad++;
            for (int i = 0; i < effLen; i++) if (rdA[COL+i] != i) rdBad++;
            check("xmem_read_seq", 64'(rdBad), 64'd0);
        end
        check("l0_wr_trails_read", 64'(l0Bad), 64'd0);
        check("load_count", 64'(loadC.size()), 64'(COL));
        if (loadC.size() == COL && rdC.size() == total) begin
            check("load_start", 64'(loadC[0]), 64'(rdC[COL-1] + 2));
            check("load_contiguous", 64'(loadC[COL-1] - loadC[0]), 64'(COL - 1));
            for (int k = 0; k < COL; k++) if (!instLog[loadC[k]][3]) exBad++;
        end
        check("exec_count", 64'(exeC.size()), 64'(effLen + ROW + COL));
        if (exeC.size() == effLen + ROW + COL && loadC.size() == COL && rdC.size() == total) begin
            check("exec_start", 64'(exeC[0]), 64'(loadC[COL-1] + 2));
            check("exec_contiguous", 64'(exeC[exeC.size()-1] - exeC[0]), 64'(effLen + ROW + COL - 1));
            for (int i = 0; i < effLen; i++) begin
                if (rdC[COL+i] != exeC[0] + i) exBad++;
                if (!instLog[exeC[0] + i][3]) exBad++;
            end
            check("exec_reads_and_l0_rd", 64'(exBad), 64'd0);
            for (int t = 0; t < lastC; t++) begin
                expOf = (t >= exeC[exeC.size()-1]) && cvLog[t] && (got < effLen);
                if (expOf) got++;
                if (instLog[t+1][6] !== expOf) ofBad++;
            end
            check("ofifo_rd_pattern", 64'(ofBad), 64'd0);
        end
        check("psum_write_count", 64'(psA.size()), 64'(effLen));
        if (psA.size() == effLen && ofC.size() == effLen) begin
            for (int i = 0; i < effLen; i++) if (psA[i] != i || psC[i] != ofC[i] + 1) psBad++;
            check("psum_after_ofifo", 64'(psBad), 64'd0);
            check("done_timing", 64'(doneAt), 64'(psC[effLen-1] + 1));
        end
        check("done_once", 64'(doneCnt), 64'd1);
        check("busy_at_done", 64'(busyLog[doneAt]), 64'd1);
        check("busy_falls", 64'(busyLog[doneAt+1]), 64'd0);
        check("mode_bit", 64'(modeBad), 64'd0);
        check("reserved_bits_zero", 64'(badBits), 64'd0);
        $display("tile len=%0d kbase=%03h mode=%0d vmode=%0d cv=%0d%% spur=%0d done@%0d",
                 len, kbase, mode, vMode, cvPct, spurious, doneAt);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.cfg_len    = '0;
        bus.cfg_kbase  = '0;
        bus.cfg_mode   = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.core_valid = 1'b0;
        reset          = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_inst", 64'(bus.inst), 64'(NOP));
        check("reset_dxmem", 64'(bus.D_xmem), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd0);
        $display("reset values checked");
        reset = 1'b1;
        @(negedge clk);

        runTile(4, 11'h400, 1'b1, 0, 100, 1'b0, 1'b0);
        runTile(4, 11'h400, 1'b1, 1, 100, 1'b0, 1'b0);
        runTile(3, 11'h7FC, 1'b0, 2, 50, 1'b1, 1'b0);
        runTile(0, 11'($urandom), 1'b1, 2, 40, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) begin
            runTile($urandom_range(1, 20), 11'($urandom), 1'($urandom), 2,
                    $urandom_range(30, 90), 1'b1, 1'b0);
        end
        runTile(6, 11'h123, 1'b1, 0, 100, 1'b0, 1'b1);
        runTile($urandom_range(1, 12), 11'($urandom), 1'($urandom), 2, 60, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
